// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED palette PWM driver.
package led_pwm_pkg;

    // One PWM period is this many compare steps (counter 0..254).
    localparam int c_pwm_steps = 255;

    typedef logic [7:0] t_duty;

    // Clocks per compare step: floor(fclk / (freq * 255)), never below 1.
    function automatic int f_ce_divisor(input int fclk, input int freq);
        int d;
        d = fclk / (freq * c_pwm_steps);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// Free-running prescaler producing a one-cycle clock enable every par_ce_divisor clocks.
module clock_enable_divider #(
    parameter int par_ce_divisor = 1
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_ce_mhz,
    output logic o_ce
);
    localparam int CW = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
    localparam logic [CW-1:0] c_last = CW'(par_ce_divisor - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Prescaler next state: count 0..divisor-1 while enabled, then wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (i_ce_mhz) begin
            cnt_d = (cnt_q == c_last) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge i_clk or posedge i_srst) begin
        if (i_srst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign o_ce = i_ce_mhz && (cnt_q == c_last);

endmodule

// File: rtl/led_palette_pwm_driver.sv
// PWM driver for RGB and basic LEDs; duties are shadowed once per 255-step period.
module led_palette_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int parm_color_led_count = 4,
    parameter int parm_basic_led_count = 4,
    parameter int parm_FCLK            = 40_000_000,
    parameter int parm_pwm_freq        = 1000
) (
    input  logic                              i_clk,
    input  logic                              i_srst,
    input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
    input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
    output logic [parm_color_led_count-1:0]   o_color_led_red,
    output logic [parm_color_led_count-1:0]   o_color_led_green,
    output logic [parm_color_led_count-1:0]   o_color_led_blue,
    output logic [parm_basic_led_count-1:0]   o_basic_led,
    output logic                              o_period_strobe
);
    localparam int NC    = parm_color_led_count;
    localparam int NB    = parm_basic_led_count;
    localparam int c_div = f_ce_divisor(parm_FCLK, parm_pwm_freq);
    localparam t_duty c_last_step = t_duty'(c_pwm_steps - 1);

    logic ce;
    logic wrap;

    t_duty step_q, step_d;
    logic  first_q, first_d;

    t_duty [NC-1:0] red_sh_q, red_sh_d;
    t_duty [NC-1:0] grn_sh_q, grn_sh_d;
    t_duty [NC-1:0] blu_sh_q, blu_sh_d;
    t_duty [NB-1:0] bas_sh_q, bas_sh_d;

    logic [NC-1:0] red_d, grn_d, blu_d;
    logic [NB-1:0] bas_d;

    clock_enable_divider #(
        .par_ce_divisor(c_div)
    ) u_ce_div (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_ce_mhz(1'b1),
        .o_ce    (ce)
    );

    // The first step after reset counts as a wrap so shadows load immediately.
    assign wrap = ce && (first_q || (step_q == c_last_step));

    // Step counter and shadow next state; shadows only move on a wrap.
    always_comb begin
        step_d   = step_q;
        first_d  = first_q;
        red_sh_d = red_sh_q;
        grn_sh_d = grn_sh_q;
        blu_sh_d = blu_sh_q;
        bas_sh_d = bas_sh_q;
        if (wrap) begin
            step_d   = '0;
            first_d  = 1'b0;
            red_sh_d = i_color_led_red_value;
            grn_sh_d = i_color_led_green_value;
            blu_sh_d = i_color_led_blue_value;
            bas_sh_d = i_basic_led_lumin_value;
        end else if (ce) begin
            step_d = step_q + 8'd1;
        end
    end

    // Counter, first-load flag and shadow registers.
    always_ff @(posedge i_clk or posedge i_srst) begin
        if (i_srst) begin
            step_q   <= '0;
            first_q  <= 1'b1;
            red_sh_q <= '0;
            grn_sh_q <= '0;
            blu_sh_q <= '0;
            bas_sh_q <= '0;
        end else begin
            step_q   <= step_d;
            first_q  <= first_d;
            red_sh_q <= red_sh_d;
            grn_sh_q <= grn_sh_d;
            blu_sh_q <= blu_sh_d;
            bas_sh_q <= bas_sh_d;
        end
    end

    // Per-channel duty compare; 8'hFF stays high since the counter tops at 254.
    for (genvar g = 0; g < NC; g++) begin : g_color
        assign red_d[g] = step_q < red_sh_q[g];
        assign grn_d[g] = step_q < grn_sh_q[g];
        assign blu_d[g] = step_q < blu_sh_q[g];
    end
    for (genvar g = 0; g < NB; g++) begin : g_basic
        assign bas_d[g] = step_q < bas_sh_q[g];
    end

    // Registered pins and period strobe.
    always_ff @(posedge i_clk or posedge i_srst) begin
        if (i_srst) begin
            o_color_led_red   <= '0;
            o_color_led_green <= '0;
            o_color_led_blue  <= '0;
            o_basic_led       <= '0;
            o_period_strobe   <= 1'b0;
        end else begin
            o_color_led_red   <= red_d;
            o_color_led_green <= grn_d;
            o_color_led_blue  <= blu_d;
            o_basic_led       <= bas_d;
            o_period_strobe   <= wrap;
        end
    end

endmodule
